// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK symbol framer.
package qpsk_pkg;

  typedef logic [1:0] dibit_t;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD
  } framer_state_e;

  localparam dibit_t PRE_EVEN = 2'b11;
  localparam dibit_t PRE_ODD  = 2'b00;

  // Dibit i of a byte, MSB-first: 0 -> [7:6] ... 3 -> [1:0].
  function automatic dibit_t dibit_sel(input logic [7:0] b, input logic [1:0] i);
    dibit_t d;
    case (i)
      2'd0:    d = b[7:6];
      2'd1:    d = b[5:4];
      2'd2:    d = b[3:2];
      default: d = b[1:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/symbol_rate_gen.sv
// Baud counter: tick on the last clock of a symbol, strobe on the first.
// Latency: counter restarts at 0 the cycle after clr; no backpressure.
module symbol_rate_gen #(
  parameter int SYM_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic strobe
);

  localparam int CW = $clog2(SYM_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SYM_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
  end

  assign tick   = en && (cnt == CNT_MAX);
  assign strobe = en && (cnt == '0);

endmodule

// File: rtl/qpsk_symbol_framer.sv
// Frames payload bytes into a paced MSB-first dibit stream behind a fixed preamble.
// Latency: first preamble symbol 1 clk after byte_valid in IDLE, payload PREAMBLE_LEN*SYM_DIV later.
// Backpressure: byte_ready pulses only at symbol boundaries; a missing byte there aborts the frame.
module qpsk_symbol_framer
  import qpsk_pkg::*;
#(
  parameter int SYM_DIV      = 4,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       byte_last,
  output logic       byte_ready,
  output logic [1:0] sym_out,
  output logic       sym_valid,
  output logic       sym_strobe,
  output logic       underrun
);

  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN - 1);

  framer_state_e state;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    idx;
  logic [7:0]    shreg;
  logic          last_flag;
  logic          tick;
  logic          start;
  logic          pre_last;
  logic          load_pt;

  assign start    = (state == IDLE) && byte_valid;
  assign pre_last = (pre_cnt == PRE_MAX);

  symbol_rate_gen #(
    .SYM_DIV(SYM_DIV)
  ) u_rate (
    .clk   (clk),
    .rst   (rst),
    .en    (state != IDLE),
    .clr   (start),
    .tick  (tick),
    .strobe(sym_strobe)
  );

  // Byte request points: end of preamble, or end of a non-final byte.
  assign load_pt = tick && (((state == PREAMBLE) && pre_last) ||
                            ((state == PAYLOAD) && (idx == 2'd3) && !last_flag));
  assign byte_ready = load_pt && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      idx       <= '0;
      shreg     <= '0;
      last_flag <= 1'b0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_valid) begin
            state     <= PREAMBLE;
            pre_cnt   <= '0;
            sym_out   <= PRE_EVEN;
            sym_valid <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (tick && !pre_last) begin
            pre_cnt <= pre_cnt + PW'(1);
            sym_out <= pre_cnt[0] ? PRE_EVEN : PRE_ODD;
          end
        end
        PAYLOAD: begin
          if (tick && (idx != 2'd3)) begin
            idx     <= idx + 2'd1;
            sym_out <= dibit_sel(shreg, idx + 2'd1);
          end else if (tick && last_flag) begin
            state     <= IDLE;
            sym_out   <= '0;
            sym_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (load_pt) begin
        if (byte_valid) begin
          state     <= PAYLOAD;
          idx       <= '0;
          shreg     <= byte_data;
          last_flag <= byte_last;
          sym_out   <= byte_data[7:6];
        end else begin
          state     <= IDLE;
          underrun  <= 1'b1;
          sym_out   <= '0;
          sym_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_framer.sv
// Randomized bench for qpsk_symbol_framer against a frame-position reference model.
module tb_qpsk_symbol_framer;

  localparam int D  = 4;
  localparam int PL = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  logic [1:0] sym_out;
  logic       sym_valid;
  logic       sym_strobe;
  logic       underrun;

  qpsk_symbol_framer #(.SYM_DIV(D), .PREAMBLE_LEN(PL)) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_last (byte_last),
    .byte_ready(byte_ready),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .sym_strobe(sym_strobe),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame described by cycle position f since frame start.
  bit         m_active;
  int         m_f;
  bit         m_und;
  bit         m_last;
  logic [7:0] m_bytes[$];

  function automatic int m_sym();
    int s, d;
    s = m_f / D;
    if (s < PL) return (s % 2 == 0) ? 3 : 0;
    d = s - PL;
    if (d / 4 >= m_bytes.size()) return -1;
    return (m_bytes[d/4] >> (6 - 2 * (d % 4))) & 3;
  endfunction

  function automatic bit m_ready();
    int s;
    s = m_f / D;
    if (!m_active || (m_f % D != D - 1)) return 0;
    return (s == PL - 1) || (s >= PL && ((s - PL) % 4 == 3) && !m_last);
  endfunction

  function automatic bit m_end();
    int s;
    s = m_f / D;
    return m_active && (m_f % D == D - 1) && s >= PL && ((s - PL) % 4 == 3) && m_last;
  endfunction

  task automatic model_update(input bit r, input bit v, input logic [7:0] d, input bit l);
    bit rdy, fin;
    rdy = m_ready();
    fin = m_end();
    if (r) begin
      m_active = 0; m_f = 0; m_und = 0; m_last = 0; m_bytes.delete();
    end else begin
      m_und = 0;
      if (!m_active) begin
        if (v) begin
          m_active = 1; m_f = 0; m_last = 0; m_bytes.delete();
        end
      end else if (rdy && v) begin
        m_bytes.push_back(d); m_last = l; m_f++;
      end else if (rdy) begin
        m_active = 0; m_und = 1;
      end else if (fin) begin
        m_active = 0;
      end else begin
        m_f++;
      end
    end
  endtask

  int  n_br, n_valid, n_strobe, n_und, n_frames, n_iter;
  bit  prev_valid;
  bit  took;
  logic [8:0] txq[$];

  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit l, input bit chk);
    bit exp_br;
    rst = r; byte_valid = v; byte_data = d; byte_last = l;
    #1;
    exp_br = !r && m_ready();
    if (chk) begin
      check("sym_valid", int'(sym_valid), int'(m_active));
      check("sym_strobe", int'(sym_strobe), int'(m_active && (m_f % D == 0)));
      check("sym_out", int'(sym_out), m_active ? m_sym() : 0);
      check("underrun", int'(underrun), int'(m_und));
      check("byte_ready", int'(byte_ready), int'(exp_br));
    end
    n_br     += int'(byte_ready);
    n_valid  += int'(sym_valid);
    n_strobe += int'(sym_strobe);
    n_und    += int'(underrun);
    if (sym_valid && !prev_valid) n_frames++;
    prev_valid = sym_valid;
    took = exp_br && v;
    @(posedge clk);
    model_update(r, v, d, l);
    #1;
  endtask

  // Feeds txq until the model is idle and the queue drained, then one idle tail cycle.
  task automatic run(input int rst_at, input int stall_pct, input int budget);
    int it;
    bit r, v;
    logic [7:0] d;
    bit l;
    it = 0;
    n_br = 0; n_valid = 0; n_strobe = 0; n_und = 0; n_frames = 0;
    do begin
      r = (it == rst_at);
      v = (txq.size() > 0) && ($urandom_range(99) >= stall_pct);
      d = v ? txq[0][7:0] : 8'($urandom);
      l = v ? txq[0][8] : 1'($urandom);
      cycle(r, v, d, l, 1'b1);
      if (r) txq.delete();
      else if (took) void'(txq.pop_front());
      it++;
    end while ((m_active || txq.size() > 0) && it < budget);
    check("run_done", int'(it < budget), 1);
    n_iter = it;
    cycle(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b1);
  endtask

  initial begin
    m_active = 0; m_f = 0; m_und = 0; m_last = 0;
    prev_valid = 0;

    // Reset with random inputs; first cycle's outputs are pre-reset unknowns.
    cycle(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    cycle(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    cycle(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'b1);

    // Single byte, final
    txq.push_back({1'b1, 8'hB4});
    run(-1, 0, 500);
    check("b4_ready_pulses", n_br, 1);
    check("b4_valid_cycles", n_valid, PL * D + 4 * D);
    check("b4_strobes", n_strobe, PL + 4);

    // Two contiguous bytes
    txq.push_back({1'b0, 8'h1E});
    txq.push_back({1'b1, 8'hC3});
    run(-1, 0, 500);
    check("two_ready_pulses", n_br, 2);
    check("two_strobes", n_strobe, PL + 8);
    check("two_valid_cycles", n_valid, PL * D + 8 * D);

    // Underrun after one non-final byte
    txq.push_back({1'b0, 8'h55});
    run(-1, 0, 500);
    check("und_ready_pulses", n_br, 2);
    check("und_pulses", n_und, 1);
    check("und_valid_cycles", n_valid, PL * D + 4 * D);

    // Reset during payload dibit idx=2 of the first byte
    txq.push_back({1'b0, 8'h96});
    txq.push_back({1'b1, 8'h5A});
    run(1 + PL * D + 2 * D, 0, 500);
    check("rst_ready_pulses", n_br, 1);
    check("rst_und_pulses", n_und, 0);
    txq.push_back({1'b1, 8'h3C});
    run(-1, 0, 500);
    check("after_rst_valid", n_valid, PL * D + 4 * D);

    // Back-to-back frames with byte_valid held high
    txq.push_back({1'b1, 8'hA5});
    txq.push_back({1'b1, 8'h3C});
    run(-1, 0, 500);
    check("b2b_frames", n_frames, 2);
    check("b2b_iters", n_iter, 2 * (1 + PL * D + 4 * D));

    // Random frames with stalls and occasional reset
    for (int k = 0; k < 24; k++) begin
      int nb, ra;
      nb = $urandom_range(4, 1);
      for (int b = 0; b < nb; b++) begin
        logic [7:0] db;
        logic       lb;
        db = 8'($urandom);
        lb = (b == nb - 1) && ($urandom_range(99) < 80);
        txq.push_back({lb, db});
      end
      ra = ($urandom_range(9) == 0) ? int'($urandom_range(1 + PL * D + nb * 4 * D)) : -1;
      run(ra, 10, 2000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
